// File: rtl/breakout_audio_pkg.sv
// Constants shared between the sound-effect sequencer and the top-level tone mux:
// note codes, effect ids, FSM states and the effect note/duration table.
package breakout_audio_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_DO  = 3'd1,
    NOTE_RE  = 3'd2,
    NOTE_MI  = 3'd3,
    NOTE_SOL = 3'd4
  } note_t;

  typedef enum logic [1:0] {
    SFX_WALL     = 2'd0,
    SFX_PADDLE   = 2'd1,
    SFX_BRICK    = 2'd2,
    SFX_GAMEOVER = 2'd3
  } sfx_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  function automatic note_t sfx_note(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: sfx_note = NOTE_MI;
      4'b01_00: sfx_note = NOTE_DO;
      4'b01_01: sfx_note = NOTE_SOL;
      4'b10_00: sfx_note = NOTE_SOL;
      4'b10_01: sfx_note = NOTE_MI;
      4'b10_10: sfx_note = NOTE_SOL;
      4'b11_00: sfx_note = NOTE_SOL;
      4'b11_01: sfx_note = NOTE_MI;
      4'b11_10: sfx_note = NOTE_RE;
      4'b11_11: sfx_note = NOTE_DO;
      default:  sfx_note = NOTE_OFF;
    endcase
  endfunction

  function automatic logic [7:0] sfx_ticks(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: sfx_ticks = 8'd30;
      4'b01_00: sfx_ticks = 8'd40;
      4'b01_01: sfx_ticks = 8'd40;
      4'b10_00: sfx_ticks = 8'd25;
      4'b10_01: sfx_ticks = 8'd25;
      4'b10_10: sfx_ticks = 8'd25;
      4'b11_00: sfx_ticks = 8'd100;
      4'b11_01: sfx_ticks = 8'd100;
      4'b11_10: sfx_ticks = 8'd100;
      4'b11_11: sfx_ticks = 8'd200;
      default:  sfx_ticks = 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] sfx_len(input logic [1:0] id);
    sfx_len = {1'b0, id} + 3'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler with synchronous clear; tick is high for one cycle
// out of every TICK_LIMIT, counting from the last clear.
module tick_prescaler #(
  parameter int unsigned TICK_LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(TICK_LIMIT - 1);

  logic [31:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Breakout sound-effect sequencer: latches event requests, arbitrates by fixed
// priority and plays each effect as a timed note sequence on note_sel.
module sfx_sequencer
  import breakout_audio_pkg::*;
#(
  parameter int unsigned TICK_LIMIT = 50000,
  parameter int unsigned GAP_TICKS  = 5
) (
  input  logic       clk50mhz,
  input  logic       reset_button,
  input  logic       sound_en,
  input  logic [3:0] req,
  output logic [2:0] note_sel,
  output logic       busy,
  output logic [1:0] cur_sfx,
  output logic       done
);

  state_t     state;
  logic [3:0] pend;
  logic [7:0] dur;
  logic [1:0] idx;
  logic [1:0] hi_id;
  logic       tick;
  logic       restart;
  logic       preempt;
  logic       last_note;

  function automatic logic [7:0] dur_of(input logic [7:0] t);
    dur_of = (t == 8'd0) ? 8'd1 : t;
  endfunction

  always_comb begin
    hi_id     = pend[3] ? 2'd3 : pend[2] ? 2'd2 : pend[1] ? 2'd1 : 2'd0;
    preempt   = pend[3] && (state != S_IDLE) && (cur_sfx != SFX_GAMEOVER);
    last_note = ({1'b0, idx} == (sfx_len(cur_sfx) - 3'd1));
    // Prescaler restarts on every note/gap load so each one gets whole ticks.
    restart   = (state == S_IDLE) || !sound_en || preempt || (tick && (dur <= 8'd1));
  end

  tick_prescaler #(.TICK_LIMIT(TICK_LIMIT)) u_prescaler (
    .clk   (clk50mhz),
    .rst_n (reset_button),
    .clear (restart),
    .tick  (tick)
  );

  always_ff @(posedge clk50mhz) begin
    if (!reset_button) begin
      state    <= S_IDLE;
      pend     <= '0;
      note_sel <= NOTE_OFF;
      busy     <= 1'b0;
      cur_sfx  <= '0;
      done     <= 1'b0;
      dur      <= '0;
      idx      <= '0;
    end else if (!sound_en) begin
      state    <= S_IDLE;
      pend     <= '0;
      note_sel <= NOTE_OFF;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= pend | req;
      if (preempt) begin
        pend     <= (pend & 4'b0111) | req;
        cur_sfx  <= SFX_GAMEOVER;
        idx      <= '0;
        dur      <= dur_of(sfx_ticks(SFX_GAMEOVER, 2'd0));
        note_sel <= sfx_note(SFX_GAMEOVER, 2'd0);
        state    <= S_PLAY;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (|pend) begin
            pend     <= (pend & ~(4'b0001 << hi_id)) | req;
            cur_sfx  <= hi_id;
            idx      <= '0;
            dur      <= dur_of(sfx_ticks(hi_id, 2'd0));
            note_sel <= sfx_note(hi_id, 2'd0);
            state    <= S_PLAY;
            busy     <= 1'b1;
          end
          S_PLAY: if (tick) begin
            if (dur > 8'd1) begin
              dur <= dur - 8'd1;
            end else if (last_note) begin
              state    <= S_IDLE;
              note_sel <= NOTE_OFF;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (GAP_TICKS > 0) begin
              state    <= S_GAP;
              note_sel <= NOTE_OFF;
              dur      <= 8'(GAP_TICKS);
              idx      <= idx + 2'd1;
            end else begin
              idx      <= idx + 2'd1;
              dur      <= dur_of(sfx_ticks(cur_sfx, idx + 2'd1));
              note_sel <= sfx_note(cur_sfx, idx + 2'd1);
            end
          end
          S_GAP: if (tick) begin
            if (dur > 8'd1) begin
              dur <= dur - 8'd1;
            end else begin
              state    <= S_PLAY;
              dur      <= dur_of(sfx_ticks(cur_sfx, idx));
              note_sel <= sfx_note(cur_sfx, idx);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with TICK_LIMIT=4, GAP_TICKS=2:
// a vector table for the basic effects plus sequences for preemption and merging.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       reset_button;
  logic       sound_en;
  logic [3:0] req;
  logic [2:0] note_sel;
  logic       busy;
  logic [1:0] cur_sfx;
  logic       done;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned done_cnt = 0;

  sfx_sequencer #(.TICK_LIMIT(4), .GAP_TICKS(2)) dut (
    .clk50mhz     (clk),
    .reset_button (reset_button),
    .sound_en     (sound_en),
    .req          (req),
    .note_sel     (note_sel),
    .busy         (busy),
    .cur_sfx      (cur_sfx),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  rq;
    int unsigned n;
    logic [2:0]  note;
    logic        bsy;
    logic [1:0]  cur;
    logic        dn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic en, input logic [3:0] rq,
                              input int unsigned n, input logic [2:0] note,
                              input logic bsy, input logic [1:0] cur, input logic dn);
    vec_t v;
    v.rst = rst; v.en = en; v.rq = rq; v.n = n;
    v.note = note; v.bsy = bsy; v.cur = cur; v.dn = dn;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive req for the first edge only, advance n edges, settle past the edge.
  task automatic go(input logic [3:0] rq, input int unsigned n);
    req = rq;
    repeat (n) begin
      @(posedge clk);
      #1;
      req = '0;
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] note, input logic bsy,
                            input logic [1:0] cur, input logic dn);
    chk({tag, " note_sel"}, {5'd0, note_sel}, {5'd0, note});
    chk({tag, " busy"},     {7'd0, busy},     {7'd0, bsy});
    chk({tag, " cur_sfx"},  {6'd0, cur_sfx},  {6'd0, cur});
    chk({tag, " done"},     {7'd0, done},     {7'd0, dn});
  endtask

  int unsigned d0;

  initial begin
    reset_button = 1'b0;
    sound_en     = 1'b1;
    req          = '0;

    // reset, with a request asserted during reset that must be lost
    add(0, 1, 4'h1, 3,   0, 0, 0, 0);
    add(1, 1, 4'h0, 5,   0, 0, 0, 0);
    // wall: mi for 30 ticks = 120 cycles
    add(1, 1, 4'h1, 1,   0, 0, 0, 0);
    add(1, 1, 4'h0, 1,   3, 1, 0, 0);
    add(1, 1, 4'h0, 119, 3, 1, 0, 0);
    add(1, 1, 4'h0, 1,   0, 0, 0, 1);
    add(1, 1, 4'h0, 1,   0, 0, 0, 0);
    // paddle: do 160, gap 8, sol 160
    add(1, 1, 4'h2, 2,   1, 1, 1, 0);
    add(1, 1, 4'h0, 159, 1, 1, 1, 0);
    add(1, 1, 4'h0, 1,   0, 1, 1, 0);
    add(1, 1, 4'h0, 7,   0, 1, 1, 0);
    add(1, 1, 4'h0, 1,   4, 1, 1, 0);
    add(1, 1, 4'h0, 159, 4, 1, 1, 0);
    add(1, 1, 4'h0, 1,   0, 0, 1, 1);
    add(1, 1, 4'h0, 1,   0, 0, 1, 0);
    // brick and wall together: brick first, one idle cycle, then wall
    add(1, 1, 4'h5, 2,   4, 1, 2, 0);
    add(1, 1, 4'h0, 99,  4, 1, 2, 0);
    add(1, 1, 4'h0, 1,   0, 1, 2, 0);
    add(1, 1, 4'h0, 8,   3, 1, 2, 0);
    add(1, 1, 4'h0, 100, 0, 1, 2, 0);
    add(1, 1, 4'h0, 8,   4, 1, 2, 0);
    add(1, 1, 4'h0, 100, 0, 0, 2, 1);
    add(1, 1, 4'h0, 1,   3, 1, 0, 0);
    add(1, 1, 4'h0, 120, 0, 0, 0, 1);
    add(1, 1, 4'h0, 1,   0, 0, 0, 0);
    // sound_en drop mid-note discards the pending paddle and later requests
    add(1, 1, 4'h1, 2,   3, 1, 0, 0);
    add(1, 1, 4'h2, 50,  3, 1, 0, 0);
    add(1, 0, 4'h0, 1,   0, 0, 0, 0);
    add(1, 0, 4'hF, 1,   0, 0, 0, 0);
    add(1, 0, 4'h2, 5,   0, 0, 0, 0);
    add(1, 1, 4'h0, 10,  0, 0, 0, 0);
    add(1, 1, 4'h0, 200, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_button = tbl[i].rst;
      sound_en     = tbl[i].en;
      go(tbl[i].rq, tbl[i].n);
      expect_out($sformatf("vec%0d", i), tbl[i].note, tbl[i].bsy, tbl[i].cur, tbl[i].dn);
    end

    // game over preempts brick in the middle of its second note
    d0 = done_cnt;
    go(4'h4, 2);   expect_out("pre brick", 4, 1, 2, 0);
    go(4'h0, 149); expect_out("pre brick n2", 3, 1, 2, 0);
    go(4'h8, 1);   expect_out("pre latch", 3, 1, 2, 0);
    go(4'h0, 1);   expect_out("pre go n1", 4, 1, 3, 0);
    go(4'h0, 399); expect_out("pre go n1 end", 4, 1, 3, 0);
    go(4'h0, 1);   expect_out("pre gap1", 0, 1, 3, 0);
    go(4'h0, 8);   expect_out("pre go n2", 3, 1, 3, 0);
    go(4'h0, 400); expect_out("pre gap2", 0, 1, 3, 0);
    go(4'h0, 8);   expect_out("pre go n3", 2, 1, 3, 0);
    go(4'h0, 400); expect_out("pre gap3", 0, 1, 3, 0);
    go(4'h0, 8);   expect_out("pre go n4", 1, 1, 3, 0);
    go(4'h0, 799); expect_out("pre go n4 end", 1, 1, 3, 0);
    go(4'h0, 1);   expect_out("pre go done", 0, 0, 3, 1);
    go(4'h0, 20);  expect_out("pre no resume", 0, 0, 3, 0);
    chk("pre done pulses", 8'(done_cnt - d0), 8'd1);

    // repeated paddle requests while paddle plays merge into one replay
    d0 = done_cnt;
    go(4'h2, 2);   expect_out("rep start", 1, 1, 1, 0);
    go(4'h2, 10);  expect_out("rep pulse1", 1, 1, 1, 0);
    go(4'h2, 10);  expect_out("rep pulse2", 1, 1, 1, 0);
    go(4'h2, 10);  expect_out("rep pulse3", 1, 1, 1, 0);
    go(4'h0, 298); expect_out("rep done1", 0, 0, 1, 1);
    go(4'h0, 1);   expect_out("rep replay", 1, 1, 1, 0);
    go(4'h0, 328); expect_out("rep done2", 0, 0, 1, 1);
    go(4'h0, 40);  expect_out("rep quiet", 0, 0, 1, 0);
    chk("rep done pulses", 8'(done_cnt - d0), 8'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer for the Breakout audio path. It accepts one-cycle event requests from game logic (wall bounce, paddle hit, brick hit, game over) and arbitrates them by fixed priority. It plays each effect as a timed sequence of notes, driving the 3-bit tone select consumed by the top-level tone mux and sine ROM stepper. It runs on `clk50mhz`, alongside the ball and paddle logic.

## Interface
- `TICK_LIMIT`, 50000: `clk50mhz` cycles per duration tick (1 ms at 50 MHz).
- `GAP_TICKS`, 5: silent ticks inserted between consecutive notes of one effect; 0 means no gap.
- `clk50mhz`  in  1  system clock; the only clock.
- `reset_button`  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low.
- `sound_en`  in  1  audio enable; 0 mutes output and discards all requests.
- `req`  in  4  event pulses: [0] wall, [1] paddle, [2] brick, [3] game over.
- `note_sel`  out  3  tone select: 0 silent, 1 do, 2 re, 3 mi, 4 sol.
- `busy`  out  1  high while in PLAY or GAP.
- `cur_sfx`  out  2  id of the effect in progress; holds its last value when idle.
- `done`  out  1  one-cycle pulse when an effect completes naturally.

## Operation
- Effect table, as (note, ticks) pairs:
  - 0 wall: (mi,30).
  - 1 paddle: (do,40), (sol,40).
  - 2 brick: (sol,25), (mi,25), (sol,25).
  - 3 game over: (sol,100), (mi,100), (re,100), (do,200).
- Pending latches `pend[3:0]`:
  - Set on any edge where `req[i]`=1.
  - Cleared when effect i is loaded.
  - Set wins over a clear on the same edge.
  - A repeated request while pending merges; there is no counting.
- States: IDLE, PLAY, GAP.
- IDLE:
  - Outputs `note_sel`=0.
  - If any `pend` bit is set, it loads the highest id: note 0, duration counter = table ticks, prescaler cleared, `note_sel` = table note, `cur_sfx` = id, then goes to PLAY.
- PLAY: the duration counter decrements on each tick. On the tick where it reaches 0:
  - If more notes remain and `GAP_TICKS`>0, go to GAP with `note_sel`=0.
  - If more notes remain and `GAP_TICKS`=0, load the next note directly.
  - If this was the last note, go to IDLE with `note_sel`=0 and `done`=1 for one cycle.
- GAP: after `GAP_TICKS` ticks, load the next note and go to PLAY.
- Preemption: only `pend[3]` preempts. If it is set while PLAY/GAP is running effect 0–2:
  - The next edge loads effect 3 directly.
  - No `done` pulse is issued.
  - The aborted effect is dropped, not resumed.
- Lower-priority pending requests wait and play after the current effect in priority order.
- Game over during game over: the request stays pending and the effect replays after completion.
- Table durations of 0 are treated as 1.
- `sound_en`=0: on the next edge, state goes to IDLE, `pend` clears, `note_sel`=0, and `done` stays 0. Requests are ignored while low.
- Reset: state IDLE, `pend`=0, `note_sel`=0, `busy`=0, `cur_sfx`=0, `done`=0, all counters 0.

## Timing
- All outputs are registered.
- `req[i]` sampled at edge k sets `pend[i]` at edge k. From IDLE, `note_sel` becomes valid after edge k+1.
- Each note lasts exactly ticks×`TICK_LIMIT` cycles, because the prescaler restarts at every note/gap load.
- Each gap lasts exactly `GAP_TICKS`×`TICK_LIMIT` cycles.
- Back-to-back effects have exactly one IDLE cycle (`note_sel`=0) between the last note and the next effect's first note.
- Prescaler width is 32 bits; duration counter width is 8 bits.

## Structure
- `breakout_audio_pkg` holds the constants shared with the top-level tone mux:
  - note codes NOTE_OFF/DO/RE/MI/SOL;
  - SFX_WALL/PADDLE/BRICK/GAMEOVER ids;
  - the effect table (note/ticks per index, length per effect).
- Sub-module `tick_prescaler`: counter with sync clear, emits a one-cycle `tick` every `TICK_LIMIT` cycles.

## Test plan
Sim uses `TICK_LIMIT`=4 and `GAP_TICKS`=2.
- Reset low 3 cycles, then `req[0]` pulse at cycle 10 -> `note_sel`=3 from cycle 11 for 120 cycles, then 0 with `done`=1 for one cycle and `busy`=0.
- `req[1]` alone -> do for 160 cycles, silent for 8, sol for 160, then `done`.
- `req[0]` and `req[2]` on the same cycle -> brick plays first (3 notes, `cur_sfx`=2), one idle cycle, then wall plays; two `done` pulses.
- Brick playing, `req[3]` at mid-second-note -> next cycle `note_sel`=4 with `cur_sfx`=3; no `done` for brick; full 4-note game-over sequence follows.
- `req[1]` pulsed 3 times during a paddle effect -> exactly one replay afterward.
- `sound_en` dropped mid-note -> next cycle `note_sel`=0, `busy`=0, `pend`=0; `req` pulses while low produce no sound after re-enable.
